// File: rtl/rank_select_pkg.sv
// rank_pkg: shared constants and types for the rank_select slice.
//   NUM_RANKS / SCORE_W / ID_W : default kernel count, score width, id width
//   rank_id_t / score_t        : id and score types at the default widths
//   state_e                    : rank_select control states
// Configuration macro: RANK_SELECT_MARGIN_EN (not referenced here).
package rank_pkg;

    localparam int unsigned NUM_RANKS = 13;
    localparam int unsigned SCORE_W   = 11;
    localparam int unsigned ID_W      = 4;

    typedef logic [ID_W-1:0]    rank_id_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT
    } state_e;

endpackage

// File: rtl/rank_select_min2_tracker.sv
// min2_tracker: running minimum (and optional second minimum) of the scores
// presented with upd, with the id of the minimum.
//   clk, rst : clock, synchronous active-high reset
//   clr      : reinitialise (best = second = all-ones, best_id = 0); wins over upd
//   upd      : fold id/score into the running minimum this cycle
//   id/score : candidate kernel id and mismatch score
//   best, best_id, second : current tracker state (second only with the macro)
// Configuration macro: RANK_SELECT_MARGIN_EN enables the second-best register.
module min2_tracker #(
    parameter int unsigned SCORE_W = rank_pkg::SCORE_W,
    parameter int unsigned ID_W    = rank_pkg::ID_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               upd,
    input  logic [ID_W-1:0]    id,
    input  logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic [ID_W-1:0]    best_id
`ifdef RANK_SELECT_MARGIN_EN
    ,
    output logic [SCORE_W-1:0] second
`endif
);

    logic [SCORE_W-1:0] best_q, best_d;
    logic [ID_W-1:0]    best_id_q, best_id_d;
`ifdef RANK_SELECT_MARGIN_EN
    logic [SCORE_W-1:0] second_q, second_d;
`endif

    // Strict compares: a tie never displaces the earlier arrival.
    always_comb begin
        best_d    = best_q;
        best_id_d = best_id_q;
`ifdef RANK_SELECT_MARGIN_EN
        second_d  = second_q;
`endif
        if (clr) begin
            best_d    = '1;
            best_id_d = '0;
`ifdef RANK_SELECT_MARGIN_EN
            second_d  = '1;
`endif
        end else if (upd) begin
            if (score < best_q) begin
                best_d    = score;
                best_id_d = id;
`ifdef RANK_SELECT_MARGIN_EN
                second_d  = best_q;
`endif
            end
`ifdef RANK_SELECT_MARGIN_EN
            else if (score < second_q) begin
                second_d = score;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q    <= '1;
            best_id_q <= '0;
`ifdef RANK_SELECT_MARGIN_EN
            second_q  <= '1;
`endif
        end else begin
            best_q    <= best_d;
            best_id_q <= best_id_d;
`ifdef RANK_SELECT_MARGIN_EN
            second_q  <= second_d;
`endif
        end
    end

    assign best    = best_q;
    assign best_id = best_id_q;
`ifdef RANK_SELECT_MARGIN_EN
    assign second  = second_q;
`endif

endmodule

// File: rtl/rank_select.sv
// rank_select: collects one mismatch score per rank kernel for a card corner
// and reports the kernel with the lowest score, once per card.
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, (re)starts collection for a new card
//   score_valid/score_id/score : one score per cycle from the XOR scorers
//   busy            : high while collecting
//   result_valid    : one-cycle pulse per completed card
//   result_id/result_score/result_ok : winner, its score, confidence (held)
//   result_margin   : second best minus best (held; macro builds only)
// Configuration macro: RANK_SELECT_MARGIN_EN adds second-best tracking, the
// result_margin port and the MARGIN_MIN requirement on result_ok.
module rank_select #(
    parameter int unsigned NUM_KERNELS    = rank_pkg::NUM_RANKS,
    parameter int unsigned SCORE_W        = rank_pkg::SCORE_W,
    parameter int unsigned ID_W           = rank_pkg::ID_W,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MARGIN_MIN     = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               score_valid,
    input  logic [ID_W-1:0]    score_id,
    input  logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               result_valid,
    output logic [ID_W-1:0]    result_id,
    output logic [SCORE_W-1:0] result_score,
    output logic               result_ok
`ifdef RANK_SELECT_MARGIN_EN
    ,
    output logic [SCORE_W-1:0] result_margin
`endif
);

    import rank_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    // The counter reaches TIMEOUT_CYCLES-1 on the same edge that enters EMIT,
    // so the result pulse follows one cycle after the counter hits its limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rank_select: TIMEOUT_CYCLES must be at least 2");
    end
    if (MARGIN_MIN > ((1 << SCORE_W) - 1)) begin : g_bad_margin
        $error("rank_select: MARGIN_MIN exceeds the score range");
    end

    state_e                 state_q, state_d;
    logic [NUM_KERNELS-1:0] seen_q, seen_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timed_out_q, timed_out_d;
    logic                   result_valid_q, result_valid_d;
    logic [ID_W-1:0]        result_id_q, result_id_d;
    logic [SCORE_W-1:0]     result_score_q, result_score_d;
    logic                   result_ok_q, result_ok_d;
`ifdef RANK_SELECT_MARGIN_EN
    logic [SCORE_W-1:0]     result_margin_q, result_margin_d;
    logic [SCORE_W-1:0]     trk_second;
    logic [SCORE_W-1:0]     margin;
`endif

    logic               accept;
    logic               trk_clr, trk_upd;
    logic [SCORE_W-1:0] trk_best;
    logic [ID_W-1:0]    trk_best_id;
    logic               margin_ok;

    min2_tracker #(
        .SCORE_W (SCORE_W),
        .ID_W    (ID_W)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (trk_clr),
        .upd     (trk_upd),
        .id      (score_id),
        .score   (score),
        .best    (trk_best),
        .best_id (trk_best_id)
`ifdef RANK_SELECT_MARGIN_EN
        ,
        .second  (trk_second)
`endif
    );

`ifdef RANK_SELECT_MARGIN_EN
    // A single kernel has no runner-up, so its margin is unbounded.
    assign margin    = (NUM_KERNELS == 1) ? '1 : (trk_second - trk_best);
    assign margin_ok = (margin >= SCORE_W'(MARGIN_MIN));
`else
    assign margin_ok = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        seen_d         = seen_q;
        cnt_d          = cnt_q;
        timed_out_d    = timed_out_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        result_score_d = result_score_q;
        result_ok_d    = result_ok_q;
`ifdef RANK_SELECT_MARGIN_EN
        result_margin_d = result_margin_q;
`endif
        accept  = 1'b0;
        trk_clr = 1'b0;
        trk_upd = 1'b0;

        // start beats any score in the same cycle and any pending result.
        if (start) begin
            state_d     = ST_COLLECT;
            seen_d      = '0;
            cnt_d       = '0;
            timed_out_d = 1'b0;
            trk_clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_COLLECT: begin
                    accept = score_valid && (32'(score_id) < NUM_KERNELS)
                             && !seen_q[score_id];
                    if (accept) begin
                        seen_d[score_id] = 1'b1;
                        trk_upd          = 1'b1;
                    end
                    if (&seen_d) begin
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d     = ST_EMIT;
                            timed_out_d = 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    result_valid_d = 1'b1;
                    result_id_d    = trk_best_id;
                    result_score_d = trk_best;
                    result_ok_d    = !timed_out_q && margin_ok;
`ifdef RANK_SELECT_MARGIN_EN
                    result_margin_d = margin;
`endif
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seen_q         <= '0;
            cnt_q          <= '0;
            timed_out_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_score_q <= '0;
            result_ok_q    <= 1'b0;
`ifdef RANK_SELECT_MARGIN_EN
            result_margin_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            seen_q         <= seen_d;
            cnt_q          <= cnt_d;
            timed_out_q    <= timed_out_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_score_q <= result_score_d;
            result_ok_q    <= result_ok_d;
`ifdef RANK_SELECT_MARGIN_EN
            result_margin_q <= result_margin_d;
`endif
        end
    end

    assign busy         = (state_q == ST_COLLECT);
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result_score = result_score_q;
    assign result_ok    = result_ok_q;
`ifdef RANK_SELECT_MARGIN_EN
    assign result_margin = result_margin_q;
`endif

endmodule

// File: tb/tb_rank_select.sv
// tb_rank_select: directed table, hand sequences and random cards for
// rank_select (TIMEOUT_CYCLES=64). Honours RANK_SELECT_MARGIN_EN.
module tb_rank_select;

    localparam int TO   = 64;
    localparam int NK   = 13;
    localparam int MAXS = 2047;
    localparam int MMIN = 40;

    typedef struct packed {
        logic        v;
        logic [3:0]  id;
        logic [10:0] sc;
    } ev_t;

    typedef struct {
        int            n;
        ev_t [15:0]    ev;
        int            exp_edge;
        int            id;
        int            sc;
        int            ok;
        int            okm;
        int            margin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, score_valid;
    logic [3:0]  score_id;
    logic [10:0] score;
    logic        busy, result_valid, result_ok;
    logic [3:0]  result_id;
    logic [10:0] result_score;
`ifdef RANK_SELECT_MARGIN_EN
    logic [10:0] result_margin;
`endif

    int total = 0;
    int bad   = 0;

    ev_t cur_ev[$];
    ev_t pre_ev[$];
    int  m_edge, m_id, m_sc, m_ok, m_margin;
    vec_t vecs[9];

    always #5 clk = ~clk;

    rank_select #(
        .NUM_KERNELS    (NK),
        .SCORE_W        (11),
        .ID_W           (4),
        .TIMEOUT_CYCLES (TO),
        .MARGIN_MIN     (MMIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .score_valid   (score_valid),
        .score_id      (score_id),
        .score         (score),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_id     (result_id),
        .result_score  (result_score),
        .result_ok     (result_ok)
`ifdef RANK_SELECT_MARGIN_EN
        ,
        .result_margin (result_margin)
`endif
    );

    function automatic ev_t mk(input int v, input int id, input int sc);
        ev_t e;
        e.v  = 1'(v);
        e.id = 4'(id);
        e.sc = 11'(sc);
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Reference: accept in arrival order while collection is open, then rank
    // the accepted scores by sorting. An all-ones minimum never displaces the
    // initial best, so its id stays 0.
    task automatic model();
        bit seen[16];
        int sc_q[$];
        int id_q[$];
        int sq[$];
        int cnt, comp, best, second, idv;
        cnt  = 0;
        comp = -1;
        for (int i = 0; i < 16; i++) seen[i] = 0;
        for (int k = 0; k < cur_ev.size() && k <= TO - 2; k++) begin
            idv = int'(cur_ev[k].id);
            if (cur_ev[k].v && idv < NK && !seen[idv]) begin
                seen[idv] = 1;
                sc_q.push_back(int'(cur_ev[k].sc));
                id_q.push_back(idv);
                cnt++;
                if (cnt == NK) begin
                    comp = k;
                    break;
                end
            end
        end
        sq = sc_q;
        sq.sort();
        best   = (sq.size() > 0) ? sq[0] : MAXS;
        second = (sq.size() > 1) ? sq[1] : MAXS;
        m_id = 0;
        if (best != MAXS) begin
            for (int i = sc_q.size() - 1; i >= 0; i--)
                if (sc_q[i] == best) m_id = id_q[i];
        end
        m_sc     = best;
        m_margin = second - best;
        m_edge   = (comp < 0) ? TO : comp + 2;
        m_ok     = (comp < 0) ? 0 : 1;
`ifdef RANK_SELECT_MARGIN_EN
        if (m_margin < MMIN) m_ok = 0;
`endif
    endtask

    task automatic drive(input ev_t e);
        score_valid = e.v;
        score_id    = e.id;
        score       = e.sc;
    endtask

    // Entered and left just after a falling edge; start is sampled on the
    // first rising edge, the card's events on the following ones.
    task automatic run_card(input ev_t sev, input int exp_edge, input int exp_id,
                            input int exp_sc, input int exp_ok, input int exp_margin);
        int pulses;
        int at;
        logic [31:0] cid, csc, cok, cmg;
        pulses = 0;
        at  = -1;
        cid = 0;
        csc = 0;
        cok = 0;
        cmg = 0;
        start = 1'b1;
        drive(sev);
        @(negedge clk);
        start = 1'b0;
        score_valid = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("no_result_at_start", 32'(result_valid), 0);
        for (int e = 1; e <= exp_edge + 2; e++) begin
            if (e - 1 < cur_ev.size()) drive(cur_ev[e-1]);
            else score_valid = 1'b0;
            @(negedge clk);
            if (result_valid === 1'b1) begin
                pulses++;
                if (at < 0) begin
                    at  = e;
                    cid = 32'(result_id);
                    csc = 32'(result_score);
                    cok = 32'(result_ok);
`ifdef RANK_SELECT_MARGIN_EN
                    cmg = 32'(result_margin);
`endif
                end
            end
        end
        score_valid = 1'b0;
        check("pulse_count", 32'(pulses), 1);
        check("pulse_edge", 32'(at), 32'(exp_edge));
        check("result_id", cid, 32'(exp_id));
        check("result_score", csc, 32'(exp_sc));
        check("result_ok", cok, 32'(exp_ok));
`ifdef RANK_SELECT_MARGIN_EN
        check("result_margin", cmg, 32'(exp_margin));
`else
        if (exp_margin < 0) check("margin_arg", cmg, 0);
`endif
        check("busy_done", 32'(busy), 0);
        check("result_id_held", 32'(result_id), 32'(exp_id));
    endtask

    task automatic prefix(input int n);
        int rv;
        rv = 0;
        start = 1'b1;
        score_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(pre_ev[i]);
            @(negedge clk);
            if (result_valid === 1'b1) rv++;
        end
        score_valid = 1'b0;
        check("prefix_no_result", 32'(rv), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 32'(busy), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_result_id", 32'(result_id), 0);
        check("rst_result_score", 32'(result_score), 0);
        check("rst_result_ok", 32'(result_ok), 0);
`ifdef RANK_SELECT_MARGIN_EN
        check("rst_result_margin", 32'(result_margin), 0);
`endif
    endtask

    task automatic full_set(input int base, input int step);
        cur_ev.delete();
        for (int i = 0; i < NK; i++) cur_ev.push_back(mk(1, i, base + step * (NK - i)));
    endtask

    initial begin
        int p[13];
        int tmp, j, okv, n;

        // Directed table.
        for (int v = 0; v < 9; v++) vecs[v].ev = '0;
        vecs[0].n = 13;
        for (int i = 0; i < 13; i++) vecs[0].ev[i] = mk(1, i, (i == 5) ? 12 : 300 + i);
        vecs[0].exp_edge = 14; vecs[0].id = 5; vecs[0].sc = 12;
        vecs[0].ok = 1; vecs[0].okm = 1; vecs[0].margin = 288;
        vecs[1].n = 13;
        for (int i = 0; i < 13; i++) vecs[1].ev[i] = mk(1, i, (i == 3 || i == 9) ? 50 : 500);
        vecs[1].exp_edge = 14; vecs[1].id = 3; vecs[1].sc = 50;
        vecs[1].ok = 1; vecs[1].okm = 0; vecs[1].margin = 0;
        vecs[2].n = 15;
        vecs[2].ev[0] = mk(1, 2, 400);
        vecs[2].ev[1] = mk(1, 2, 0);
        vecs[2].ev[2] = mk(1, 15, 0);
        n = 3;
        for (int i = 0; i < 13; i++) if (i != 2) begin vecs[2].ev[n] = mk(1, i, 200 + i); n++; end
        vecs[2].exp_edge = 16; vecs[2].id = 0; vecs[2].sc = 200;
        vecs[2].ok = 1; vecs[2].okm = 0; vecs[2].margin = 1;
        vecs[3].n = 12;
        for (int i = 0; i < 12; i++) vecs[3].ev[i] = mk(1, i, (i == 7) ? 33 : 600);
        vecs[3].exp_edge = TO; vecs[3].id = 7; vecs[3].sc = 33;
        vecs[3].ok = 0; vecs[3].okm = 0; vecs[3].margin = 567;
        vecs[4].n = 13;
        for (int i = 0; i < 13; i++) vecs[4].ev[i] = mk(1, i, (i == 4) ? 100 : (i == 8) ? 120 : 900);
        vecs[4].exp_edge = 14; vecs[4].id = 4; vecs[4].sc = 100;
        vecs[4].ok = 1; vecs[4].okm = 0; vecs[4].margin = 20;
        vecs[5].n = 16;
        n = 12;
        for (int k = 0; k < 16; k++) begin
            if (k == 2 || k == 6 || k == 10) vecs[5].ev[k] = mk(0, 3, 0);
            else begin vecs[5].ev[k] = mk(1, n, 700 - 20 * n); n--; end
        end
        vecs[5].exp_edge = 17; vecs[5].id = 12; vecs[5].sc = 460;
        vecs[5].ok = 1; vecs[5].okm = 0; vecs[5].margin = 20;
        vecs[6].n = 13;
        for (int i = 0; i < 13; i++) vecs[6].ev[i] = mk(1, i, (i == 0) ? 10 : (i == 1) ? 50 : 1000);
        vecs[6].exp_edge = 14; vecs[6].id = 0; vecs[6].sc = 10;
        vecs[6].ok = 1; vecs[6].okm = 1; vecs[6].margin = 40;
        vecs[7].n = 13;
        for (int i = 0; i < 13; i++) vecs[7].ev[i] = mk(1, i, (i == 0) ? 2039 : (i == 12) ? 2000 : 2046);
        vecs[7].exp_edge = 14; vecs[7].id = 12; vecs[7].sc = 2000;
        vecs[7].ok = 1; vecs[7].okm = 0; vecs[7].margin = 39;
        vecs[8].n = 0;
        vecs[8].exp_edge = TO; vecs[8].id = 0; vecs[8].sc = MAXS;
        vecs[8].ok = 0; vecs[8].okm = 0; vecs[8].margin = 0;

        rst = 1'b1;
        start = 1'b0;
        score_valid = 1'b0;
        score_id = '0;
        score = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals();

        for (int v = 0; v < 9; v++) begin
            cur_ev.delete();
            for (int i = 0; i < vecs[v].n; i++) cur_ev.push_back(vecs[v].ev[i]);
`ifdef RANK_SELECT_MARGIN_EN
            okv = vecs[v].okm;
`else
            okv = vecs[v].ok;
`endif
            run_card(mk(0, 0, 0), vecs[v].exp_edge, vecs[v].id, vecs[v].sc, okv, vecs[v].margin);
        end

        // start with a score in the same cycle: the score (id 0, 0) is dropped.
        cur_ev.delete();
        for (int i = 0; i < NK; i++) cur_ev.push_back(mk(1, i, (i == 0) ? 700 : 100 + i));
        model();
        run_card(mk(1, 0, 0), m_edge, m_id, m_sc, m_ok, m_margin);

        // Restart mid-collection.
        pre_ev.delete();
        for (int i = 0; i < 6; i++) pre_ev.push_back(mk(1, i, 1));
        prefix(6);
        full_set(300, 3);
        model();
        run_card(mk(0, 0, 0), m_edge, m_id, m_sc, m_ok, m_margin);

        // Reset mid-collection.
        prefix(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals();
        full_set(250, 5);
        model();
        run_card(mk(0, 0, 0), m_edge, m_id, m_sc, m_ok, m_margin);

        // start while in EMIT: the completed card never reports.
        pre_ev.delete();
        for (int i = 0; i < NK; i++) pre_ev.push_back(mk(1, i, (i == 0) ? 5 : 900));
        prefix(NK);
        full_set(400, 7);
        model();
        run_card(mk(0, 0, 0), m_edge, m_id, m_sc, m_ok, m_margin);

        // Random cards.
        for (int r = 0; r < 24; r++) begin
            cur_ev.delete();
            if (r % 2 == 0) begin
                for (int i = 0; i < NK; i++) p[i] = i;
                for (int i = NK - 1; i > 0; i--) begin
                    j = int'($urandom_range(0, i));
                    tmp = p[i]; p[i] = p[j]; p[j] = tmp;
                end
                for (int i = 0; i < NK; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        cur_ev.push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                                            int'($urandom_range(0, 60))));
                    cur_ev.push_back(mk(1, p[i], ($urandom_range(0, 1) == 1) ?
                                        int'($urandom_range(0, 60)) : int'($urandom_range(0, MAXS))));
                end
            end else begin
                n = int'($urandom_range(10, 70));
                for (int i = 0; i < n; i++)
                    cur_ev.push_back(mk(($urandom_range(0, 4) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
                                        ($urandom_range(0, 1) == 1) ?
                                        int'($urandom_range(0, 60)) : int'($urandom_range(0, MAXS))));
            end
            model();
            run_card(mk(0, 0, 0), m_edge, m_id, m_sc, m_ok, m_margin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rank_select.md
# rank_select

Downstream arbiter for the per-rank XOR kernel scorers. Collects one mismatch score per rank kernel for the current card corner and selects the rank with the lowest score, i.e. the fewest mismatched pixels. Emits a single registered result per card, plus a confidence flag, to the card-identification logic. Sits between the bank of XOR scorers and the game/display state.

## Interface
Parameters:
- NUM_KERNELS, 13: number of rank kernels (A..K); ids 0..NUM_KERNELS-1.
- SCORE_W, 11: score width, equal to clog2(28*40).
- ID_W, 4: kernel id width.
- TIMEOUT_CYCLES, 4096: maximum COLLECT duration before a forced result.
- MARGIN_MIN, 40: minimum (second best − best) required for confidence; used only when RANK_SELECT_MARGIN_EN is defined.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; synchronous, active-high.
- start, in, 1: one-cycle pulse; begins collection for a new card.
- score_valid, in, 1: score_id/score valid this cycle.
- score_id, in, ID_W: kernel that produced the score.
- score, in, SCORE_W: mismatch count.
- busy, out, 1: high in COLLECT.
- result_valid, out, 1: one-cycle pulse.
- result_id, out, ID_W: winning kernel; held until the next result.
- result_score, out, SCORE_W: winning score; held until the next result.
- result_ok, out, 1: result is trustworthy; held until the next result.
- result_margin, out, SCORE_W: second best − best; present only with RANK_SELECT_MARGIN_EN.

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- IDLE: score_valid is ignored. start → COLLECT.
- On entering COLLECT, clear the following:
  - seen mask (NUM_KERNELS bits);
  - best = all-ones, best_id = 0, second = all-ones;
  - timeout counter = 0;
  - timed_out = 0.
- Score acceptance in COLLECT: a score is accepted if score_valid=1, score_id < NUM_KERNELS and seen[score_id]=0.
  - Out-of-range and duplicate ids are dropped silently.
- Accepted score: set seen[score_id].
  - If score < best: second ← best, best ← score, best_id ← score_id.
  - Else if score < second: second ← score.
  - Equal scores keep the earlier arrival (strict compare).
- COLLECT → EMIT when the seen mask is all ones, counting the acceptance made this cycle.
- COLLECT → EMIT with timed_out=1 when the counter reaches TIMEOUT_CYCLES-1 without completion.
- EMIT: result_valid=1 and the result registers are updated, then → IDLE.
  - result_ok = (not timed_out) and margin condition (see Configuration).
  - If no score was accepted before a timeout: result_score = all-ones, result_id = 0, result_ok = 0.
- start in COLLECT or EMIT restarts collection; a result pending in EMIT is discarded (no result_valid).
- start and score_valid in the same cycle: start wins and the score is discarded.
- All arithmetic is unsigned SCORE_W bits. The margin cannot underflow because second ≥ best always.

## Timing
- Reset values:
  - state = IDLE, busy = 0, result_valid = 0;
  - result_id = 0, result_score = 0, result_ok = 0, result_margin = 0.
- rst has priority over every other input. rst mid-COLLECT abandons the card with no result.
- busy is high the cycle after start and stays high through the completing cycle.
- Result latency: result_valid is asserted 2 cycles after the cycle in which the final score is accepted (1 cycle for the COLLECT→EMIT transition, then EMIT).
- Result latency on timeout: result_valid is asserted 1 cycle after the counter reaches TIMEOUT_CYCLES-1.
- Scores may arrive back-to-back at one per cycle with no stall; there is no backpressure.

## Configuration
- RANK_SELECT_MARGIN_EN defined:
  - second-best tracking is implemented;
  - the result_margin port exists;
  - result_ok additionally requires margin ≥ MARGIN_MIN;
  - with NUM_KERNELS=1, margin = all-ones.
- RANK_SELECT_MARGIN_EN undefined:
  - no second-best register and no result_margin port;
  - result_ok = not timed_out.

## Structure
- Package rank_pkg:
  - NUM_RANKS = 13, SCORE_W = 11, ID_W = 4;
  - typedef rank_id_t (logic [ID_W-1:0]);
  - typedef score_t (logic [SCORE_W-1:0]);
  - enum for the FSM state.
- Sub-module min2_tracker holds the best/second/best_id registers and the compare/update logic.
  - Inputs: clr, upd, id, score.
  - Second-best logic sits under the macro.
- The top level holds the FSM, seen mask, timeout counter and output registers.

## Test plan
- All 13 ids in order; id 5 has score 12, the rest ≥ 300 → one result_valid 2 cycles after the last score: result_id=5, result_score=12, result_ok=1, margin=288 with the macro.
- Ids 3 and 9 both score 50, id 3 first → result_id=3.
- Duplicate id 2 with score 0 after id 2 with score 400, plus id 15 with score 0 → both dropped; id 2 does not win.
- Only 12 ids delivered, TIMEOUT_CYCLES=64 → result_valid 1 cycle after the counter reaches 63, result_ok=0, best of the 12 reported.
- Macro on, MARGIN_MIN=40, best=100, second=120 → result_ok=0, result_margin=20.
- rst asserted after 6 scores, then a fresh start with a full set → outputs at reset values, then exactly one result reflecting only the new set. A start issued mid-collection restarts likewise.
